// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns byte/half/word accesses into word-aligned
// dmem transactions with byte enables, a req/ack handshake and an ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            req_s;
  logic            mis_s;

  function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   calc_be = 4'b0001 << a;
      2'b01:   calc_be = 4'b0011 << {a[1], 1'b0};
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   calc_wdata = {4{d[7:0]}};
      2'b01:   calc_wdata = {2{d[15:0]}};
      default: calc_wdata = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and zero the bytes above the access size.
  function automatic logic [31:0] align_load(input logic [31:0] rd, input logic [1:0] off,
                                              input logic [1:0] sz);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (sz)
      2'b00:   align_load = {24'h000000, sh[7:0]};
      2'b01:   align_load = {16'h0000, sh[15:0]};
      default: align_load = sh;
    endcase
  endfunction

  assign req_s = mem_read | mem_write;
  assign mis_s = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));

  // Next-state, latch and combinational handshake outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    off_d        = off_q;
    size_d       = size_q;
    load_data_d  = load_data_q;
    stall        = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !mis_s) begin
          stall   = 1'b1;
          state_d = WAIT;
          we_d    = mem_write;
          err_d   = 1'b0;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = calc_be(size, addr[1:0]);
          wdata_d = calc_wdata(size, store_data);
          off_d   = addr[1:0];
          size_d  = size;
          cnt_d   = '0;
        end else if (req_s) begin
          misalign_err = 1'b1;
        end else begin
          misalign_err = 1'b0;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            load_data_d = align_load(dmem_rdata, off_q, size_q);
          end else begin
            load_data_d = load_data_q;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = DONE;
          err_d       = 1'b1;
          load_data_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        // EX/MEM still holds the finished instruction, so inputs are not looked at here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 32'h0000_0000;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_req   = (state_q == WAIT);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == DONE) & ~we_q & ~err_q;
  assign bus_err    = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, store_data;
  logic [1:0]  size;
  logic        stall, load_valid, misalign_err, bus_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .store_data(store_data), .size(size), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misalign_err(misalign_err),
    .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle_in(); addr = 32'h0; store_data = 32'h0; size = 2'b00;
    dmem_rdata = 32'h0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_lv", {31'd0, load_valid}, 32'd0);
    chk("rst_berr", {31'd0, bus_err}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", {28'd0, dmem_be}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_ld", load_data, 32'h0);

    // lb at 0x103, ack in first WAIT cycle
    mem_read = 1'b1; addr = 32'h0000_0103; size = 2'b00;
    #1 chk("lb_idle_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_stall_w", {31'd0, stall}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_be", {28'd0, dmem_be}, 32'h8);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hA011_2233;
    step();
    chk("lb_ld", load_data, 32'h0000_00A0);
    chk("lb_lv", {31'd0, load_valid}, 32'd1);
    chk("lb_stall_d", {31'd0, stall}, 32'd0);
    chk("lb_req_d", {31'd0, dmem_req}, 32'd0);
    idle_in();
    step();
    chk("lb_lv_idle", {31'd0, load_valid}, 32'd0);

    // sh at 0x202
    mem_write = 1'b1; addr = 32'h0000_0202; size = 2'b01; store_data = 32'hDEAD_1234;
    step();
    chk("sh_we", {31'd0, dmem_we}, 32'd1);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    chk("sh_lv", {31'd0, load_valid}, 32'd0);
    chk("sh_berr", {31'd0, bus_err}, 32'd0);
    chk("sh_ld_kept", load_data, 32'h0000_00A0);
    idle_in();
    step();

    // sb at 0x001
    mem_write = 1'b1; addr = 32'h0000_0001; size = 2'b00; store_data = 32'h1122_3355;
    step();
    chk("sb_be", {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h5555_5555);
    dmem_ack = 1'b1;
    step();
    idle_in();
    step();

    // Misaligned word and half
    mem_read = 1'b1; addr = 32'h0000_0302; size = 2'b10;
    #1;
    chk("mis_w_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_w_stall", {31'd0, stall}, 32'd0);
    step();
    chk("mis_w_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_w_still", {31'd0, misalign_err}, 32'd1);
    addr = 32'h0000_0301; size = 2'b01;
    #1 chk("mis_h_err", {31'd0, misalign_err}, 32'd1);
    addr = 32'h0000_0303; size = 2'b11;
    #1 chk("mis_s3_err", {31'd0, misalign_err}, 32'd1);
    idle_in();
    #1 chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    step();

    // lh at 0x400, ack in third WAIT cycle
    mem_read = 1'b1; addr = 32'h0000_0400; size = 2'b01;
    #1 chk("dl_stall0", {31'd0, stall}, 32'd1);
    step();
    chk("dl_be", {28'd0, dmem_be}, 32'h3);
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    chk("dl_stall2", {31'd0, stall}, 32'd1);
    step();
    chk("dl_stall3", {31'd0, stall}, 32'd1);
    chk("dl_req3", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_F000;
    step();
    chk("dl_stall_d", {31'd0, stall}, 32'd0);
    chk("dl_ld", load_data, 32'h0000_F000);
    chk("dl_lv", {31'd0, load_valid}, 32'd1);
    idle_in();
    step();

    // lhu at 0x402 -> upper half moved down
    mem_read = 1'b1; addr = 32'h0000_0402; size = 2'b01;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000;
    step();
    chk("lh2_ld", load_data, 32'h0000_BEEF);
    idle_in();
    step();

    // lw timeout
    mem_read = 1'b1; addr = 32'h0000_0500; size = 2'b10;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("to_req%0d", i), {31'd0, dmem_req}, 32'd1);
    end
    step();
    chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to_berr", {31'd0, bus_err}, 32'd1);
    chk("to_ld", load_data, 32'h0);
    chk("to_lv", {31'd0, load_valid}, 32'd0);
    idle_in();
    step();
    chk("to_berr_pulse", {31'd0, bus_err}, 32'd0);
    chk("to_idle_req", {31'd0, dmem_req}, 32'd0);

    // Reset during WAIT
    mem_read = 1'b1; addr = 32'h0000_0600; size = 2'b10;
    step();
    chk("rw_req", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0; idle_in();
    #1;
    chk("rw_req_async", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall_async", {31'd0, stall}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    mem_read = 1'b1; addr = 32'h0000_0000; size = 2'b10;
    step();
    chk("rw2_addr", dmem_addr, 32'h0);
    chk("rw2_be", {28'd0, dmem_be}, 32'hF);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    chk("rw2_ld", load_data, 32'h1234_5678);
    chk("rw2_lv", {31'd0, load_valid}, 32'd1);
    idle_in();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the 5-stage RISC-V core. It sits between the EX/MEM pipeline register and the data-memory port, directly upstream of `sign_extendmemory`. It turns byte, halfword and word accesses into word-aligned memory transactions with byte enables, and runs a req/ack handshake with a timeout. It stalls the pipeline while a transaction is outstanding. It returns lane-aligned, zero-padded load data, which `sign_extendmemory` then sign- or zero-extends.

## Interface
Parameters:
- `TIMEOUT`, default 16: number of WAIT cycles without `dmem_ack` before the access is aborted with `bus_err`.

Ports:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `mem_read`, in, 1: load request from EX/MEM.
- `mem_write`, in, 1: store request from EX/MEM. Takes precedence if asserted together with `mem_read`.
- `addr`, in, 32: byte address.
- `store_data`, in, 32: store source, right-aligned.
- `size`, in, 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `stall`, out, 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `load_data`, out, 32: lane-aligned load result for `sign_extendmemory`.
- `load_valid`, out, 1: one-cycle pulse marking that `load_data` is valid.
- `misalign_err`, out, 1: misaligned access flag; no transaction is issued.
- `bus_err`, out, 1: one-cycle pulse on timeout.
- `dmem_req`, out, 1: memory request.
- `dmem_we`, out, 1: 1 = write.
- `dmem_addr`, out, 32: word address; `{addr[31:2],2'b00}`.
- `dmem_be`, out, 4: byte enables.
- `dmem_wdata`, out, 32: lane-replicated store data.
- `dmem_rdata`, in, 32: read data, valid with `dmem_ack`.
- `dmem_ack`, in, 1: transaction complete.

## Operation
- **States:** IDLE, WAIT, DONE.
- **Misalignment:** a half access with `addr[0]=1` or a word access with `addr[1:0]!=0` is misaligned.
  - In IDLE, `misalign_err` is combinational: it is high while `(mem_read|mem_write)` is asserted and the access is misaligned.
  - A misaligned access issues no transaction, raises no stall and does not change state.
- **IDLE, valid aligned access:**
  - `stall` is high combinationally.
  - On the clock edge the unit latches `we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, the byte offset and `size`, then moves to WAIT. The timeout counter clears.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- **Store data:**
  - byte: `{4{store_data[7:0]}}`
  - half: `{2{store_data[15:0]}}`
  - word: `store_data`
- **WAIT:**
  - `dmem_req=1`, `stall=1`; all `dmem_*` outputs are held stable.
  - When `dmem_ack` is sampled high, a load registers `load_data`, and the unit moves to DONE.
  - If the counter reaches `TIMEOUT-1` with no ack, the unit moves to DONE with `bus_err` armed and `load_data=0`.
  - `dmem_rdata` is ignored when there is no ack.
- **Load alignment:** `load_data = dmem_rdata >> (8*offset)`, then masked:
  - byte: bits [31:8] zero
  - half: bits [31:16] zero
  - word: unmasked
- **DONE:**
  - `stall=0`, `dmem_req=0`.
  - `load_valid=1` for a completed load; `bus_err=1` if the access timed out.
  - The inputs are ignored because EX/MEM still holds the finished instruction. The unit always returns to IDLE.
- **Ack timing:** an ack arriving in IDLE or DONE is ignored.

## Timing
- **Reset values:**
  - state IDLE, counter 0.
  - `dmem_req`, `dmem_we`, `load_valid`, `bus_err` = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `load_data` = 0.
  - `stall` and `misalign_err` = 0 while in IDLE with no request.
- **Reset mid-access:** asynchronous assertion drops `dmem_req` immediately and returns the unit to IDLE. The transaction is lost.
- **Minimum latency** (ack in the first WAIT cycle):
  - cycle 0: IDLE, `stall=1`
  - cycle 1: WAIT, `dmem_req=1`, ack
  - cycle 2: DONE, `load_valid=1`, `stall=0`
  - Total: 2 stall cycles.
- **Ack after k WAIT cycles** (k ≥ 1): stall lasts k+1 cycles.
- **Timeout:** `bus_err` appears in cycle `TIMEOUT+1`, counted from cycle 0.
- **Back-to-back accesses:** the next access is accepted in the IDLE cycle immediately after DONE. Steady-state throughput is one access per 3 cycles.

## Test plan
- **Byte load, offset 3:** lb at `addr=0x103`, `dmem_rdata=0xA0112233`, ack in the first WAIT cycle.
  - Expect `dmem_addr=0x100`, `dmem_be=4'b1000`.
  - DONE shows `load_data=0x000000A0` and `load_valid=1`; `stall` is high for exactly 2 cycles.
- **Half store, offset 2:** sh with `addr=0x202`, `store_data=0xDEAD1234`.
  - Expect `dmem_we=1`, `dmem_be=4'b1100`, `dmem_wdata=0x12341234`, `load_valid=0`.
- **Misaligned word:** lw at `addr=0x302`.
  - Expect `misalign_err=1`, `dmem_req=0`, `stall=0`, and the state stays IDLE.
- **Delayed ack:** lh at `addr=0x400`, ack after 3 WAIT cycles, `dmem_rdata=0x0000F000`.
  - Expect `stall` high for 4 cycles, then `load_data=0x0000F000`.
- **Timeout:** with `TIMEOUT=16`, a lw that never receives an ack.
  - `dmem_req` drops after 16 WAIT cycles, then `bus_err` pulses for 1 cycle with `load_data=0`, and the unit returns to IDLE.
- **Reset during WAIT:** assert `rst_n=0` while in WAIT.
  - `dmem_req` and `stall` go to 0 without waiting for a clock edge.
  - After release, a new lw at `0x0` completes normally.
